// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default instruction-memory address and data widths
//   PC_STEP                         : byte distance between sequential instructions
//   fetch_state_t                   : fetch FSM encoding (IDLE / RUN / HOLD)
//   fetch_entry_t                   : prefetch queue entry layout {instr, pc}
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned PC_STEP        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] instr;
        logic [DEFAULT_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction fetch bus: instruction-memory read port plus the decode handshake.
//   master : fetch unit side (drives imem_addr/imem_rd_en and the out_* head)
//   slave  : memory + decode side (returns imem_instr, drives out_ready)
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [DATA_W-1:0] imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_addr, imem_rd_en, out_valid, out_instr, out_pc,
        input  imem_instr, out_ready
    );

    modport slave (
        input  imem_addr, imem_rd_en, out_valid, out_instr, out_pc,
        output imem_instr, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO used as the prefetch queue.
//   push/din  : write an entry (ignored while flush is high)
//   pop       : drop the head entry (ignored when empty)
//   flush     : empty the queue; wins over push and pop
//   dout      : head entry, forced to zero while empty
//   count     : number of valid entries
module fetch_queue #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !flush && (count != '0);
        dout    = (count == '0) ? '0 : mem[rd_ptr];
    end

    // Storage is not reset; the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one-cycle-latency reads to
// instruction memory, buffers results in a prefetch queue and presents them to
// decode over a valid/ready handshake. Redirects flush the queue and kill any
// in-flight read.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (master)   : imem_addr/imem_rd_en/imem_instr, out_valid/out_ready/out_instr/out_pc
//   redirect_valid : branch/jump redirect, redirect_pc target (low two bits ignored)
//   halt           : stop issuing new requests while high
//   busy           : read in flight or queue non-empty
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters perf_fetched
// (instructions pushed) and perf_killed (killed reads plus flushed entries).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_if.master           bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_killed
`endif
);

    localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);
    localparam int unsigned LVL_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_q;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               redir_c;
    logic               room_c;
    logic               issue_c;
    logic               push_c;
    logic               pop_c;
    logic [ADDR_W-1:0]  redir_tgt_c;

    // Issue/capture decisions; a redirect blocks issue and kills the pending response.
    always_comb begin
        redir_c     = redirect_valid && (state != ST_IDLE);
        redir_tgt_c = redirect_pc & ~ADDR_W'(PC_STEP - 1);
        room_c      = (LVL_W'(count) + LVL_W'(inflight)) < LVL_W'(QDEPTH);
        issue_c     = (state == ST_RUN) && !halt && !redir_c && room_c;
        push_c      = inflight && !redir_c;
        pop_c       = bus.out_valid && bus.out_ready;
    end

    // FSM, PC and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN:  if (halt)  state <= ST_HOLD;
                ST_HOLD: if (!halt) state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
            if (redir_c) begin
                pc <= redir_tgt_c;
            end else if (issue_c) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
            if (issue_c) begin
                pc_q <= pc;
            end
            inflight <= issue_c;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .din   ({bus.imem_instr, pc_q}),
        .pop   (pop_c),
        .flush (redir_c),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        bus.imem_addr  = pc;
        bus.imem_rd_en = issue_c;
        bus.out_valid  = (count != '0);
        bus.out_instr  = head[ENTRY_W-1:ADDR_W];
        bus.out_pc     = head[ADDR_W-1:0];
        busy           = inflight || (count != '0);
    end

`ifdef FETCH_PERF_CNT_EN
    logic [16:0] fetched_sum;
    logic [16:0] killed_sum;

    // One extra bit detects overflow so both counters stick at all-ones.
    always_comb begin
        fetched_sum = {1'b0, perf_fetched} + 17'(push_c);
        killed_sum  = {1'b0, perf_killed};
        if (redir_c) begin
            killed_sum = killed_sum + 17'(count) + 17'(inflight);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            perf_fetched <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
            perf_killed  <= killed_sum[16]  ? 16'hFFFF : killed_sum[15:0];
        end
    end
`else
    // Counters absent; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A reference model predicts the
// sequential instruction stream that decode must observe after each reset or
// redirect; a monitor compares every accepted head entry against it.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halt;
    logic       busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_killed;
`endif

    fetch_if bus ();

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .busy           (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0]  rom [256];
    fetch_entry_t exp_q [$];
    logic [7:0]   exp_next;
    int           errors = 0;
    int           checks = 0;
    int           pops   = 0;

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_instr <= rom[bus.imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keep the predicted stream a few entries ahead of decode.
    task automatic exp_fill();
        fetch_entry_t e;
        while (exp_q.size() < 16) begin
            e.pc    = exp_next;
            e.instr = rom[exp_next];
            exp_q.push_back(e);
            exp_next = exp_next + 8'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        exp_fill();
        #1;
    endtask

    task automatic redirect_to(input logic [7:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        exp_next = {tgt[7:2], 2'b00};
        exp_fill();
    endtask

    task automatic do_reset(input bit rnd_rom);
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'(RST_PC));
        chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", 32'(perf_fetched), 32'd0);
        chk("rst_perf_killed", 32'(perf_killed), 32'd0);
`endif
        if (rnd_rom) begin
            foreach (rom[i]) rom[i] = $urandom;
        end
        exp_q.delete();
        exp_next = RST_PC;
        exp_fill();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares each accepted head entry and the handshake rules.
    logic        prev_redir;
    logic        prev_hold;
    logic [7:0]  prev_pc;
    logic [31:0] prev_instr;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_redir = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_redir) chk("post_redirect_valid", 32'(bus.out_valid), 32'd0);
            if (prev_hold) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_pc", 32'(bus.out_pc), 32'(prev_pc));
                chk("stall_instr", bus.out_instr, prev_instr);
            end
            if (bus.out_valid && bus.out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", 32'(bus.out_pc), 32'(e.pc));
                    chk("out_instr", bus.out_instr, e.instr);
                    pops++;
                end
            end
            prev_redir = redirect_valid;
            prev_hold  = bus.out_valid && !bus.out_ready && !redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
        end
    end

    initial begin
        int rd_cnt;
        int pops0;
        logic [7:0] tgt;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        bus.out_ready  = 1'b0;
        foreach (rom[i]) rom[i] = 32'hA000_0000 + 32'(i);

        // First valid three edges after reset release, then one per cycle.
        do_reset(1'b0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("first_valid", 32'(bus.out_valid), (k >= 3) ? 32'd1 : 32'd0);
        end
        repeat (10) step();

        // Redirect with three queued entries and one read in flight.
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        repeat (5) step();
        chk("pre_redir_busy", 32'(busy), 32'd1);
        chk("pre_redir_head", 32'(bus.out_pc), 32'h00);
        redirect_to(8'h42);
        bus.out_ready = 1'b1;
        step();
        chk("redir_flush_valid", 32'(bus.out_valid), 32'd0);
        repeat (10) step();

        // Decode stalled: only QDEPTH requests issue.
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        rd_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.imem_rd_en) rd_cnt++;
        end
        chk("stall_req_count", 32'(rd_cnt), 32'd4);
        chk("stall_rd_en_low", 32'(bus.imem_rd_en), 32'd0);
        chk("stall_head_pc", 32'(bus.out_pc), 32'h00);
        chk("stall_head_instr", bus.out_instr, 32'hA000_0000);
        bus.out_ready = 1'b1;
        repeat (8) step();

        // PC wrap across the top of the address space.
        redirect_to(8'hF8);
        repeat (10) step();

        // Halt mid-stream: no requests, queue drains, fetch resumes in order.
        halt = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i >= 2) chk("halt_no_req", 32'(bus.imem_rd_en), 32'd0);
            if (i == 5) chk("halt_drained_busy", 32'(busy), 32'd0);
        end
        halt = 1'b0;
        pops0 = pops;
        repeat (10) step();
        chk("halt_resume_progress", 32'(pops - pops0 >= 5), 32'd1);

        // Asynchronous reset with a full queue.
        bus.out_ready = 1'b0;
        repeat (8) step();
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_rd_en", 32'(bus.imem_rd_en), 32'd0);
        do_reset(1'b0);
        bus.out_ready = 1'b1;
        repeat (10) step();

        // Randomized traffic against the stream model.
        do_reset(1'b1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        pops0 = pops;
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 8) halt = !halt;
            if ($urandom_range(0, 99) < 3) begin
                tgt = 8'($urandom);
                redirect_to(tgt);
            end
        end
        chk("random_progress", 32'(pops - pops0 >= 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface: owns the program counter and drives a byte address into the instruction memory. The memory returns a 32-bit instruction one clock later. Results are buffered in a small prefetch queue and handed to decode through a valid/ready handshake. Branch redirects flush the queue and any in-flight read.

Parameters:
ADDR_W, 8, byte address width of instruction memory
DATA_W, 32, instruction width
QDEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, PC after reset (word aligned)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDR_W  byte address to instruction memory
imem_rd_en  out  1  read request this cycle
imem_instr  in  DATA_W  instruction, valid the cycle after a request
redirect_valid  in  1  branch/jump redirect
redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0
halt  in  1  stop issuing new requests while high
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  DATA_W  queue head instruction
out_pc  out  ADDR_W  byte address of out_instr
busy  out  1  request in flight or queue non-empty

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; queue empty; inflight=0; state=IDLE; imem_rd_en=0; imem_addr=RESET_PC; out_valid=0; out_instr=0; out_pc=0; busy=0.
- FSM states and transitions:
  - IDLE: first cycle after reset deassertion; no request issued; always goes to RUN.
  - RUN: issues requests; goes to HOLD when halt=1.
  - HOLD: no new requests; the in-flight response is still captured; returns to RUN when halt=0.
- Issue rule (RUN only): imem_rd_en=1 when count + inflight < QDEPTH and no redirect this cycle.
  - imem_addr=pc, combinational from the pc register.
  - On issue: pc <= pc+4, wrapping modulo 2^ADDR_W (0xFC -> 0x00). inflight <= 1, and pc_q <= pc.
- Capture: on the cycle after an issue, if inflight=1 and no kill, push {imem_instr, pc_q} into the queue.
- Memory latency is exactly 1 cycle. Steady-state throughput is one instruction/cycle while decode accepts every cycle.
- Handshake:
  - out_valid = queue non-empty. out_instr and out_pc are the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - out_instr and out_pc hold stable while out_valid=1 and out_ready=0.
- Redirect (highest priority, any state except IDLE):
  - Same edge: queue emptied (count=0); pc <= {redirect_pc[ADDR_W-1:2],2'b00}; imem_rd_en=0 that cycle; any in-flight response is killed, i.e. not pushed on the next edge.
  - First request to the target issues the following cycle if in RUN.
  - out_valid is 0 the cycle after the redirect.
  - A pop coinciding with a redirect is lost; decode is responsible for ignoring it.
  - Redirect during HOLD updates pc; fetch resumes at the target when halt drops.
- Full queue: no issue. Empty queue: out_valid=0.
- busy = inflight | (count != 0).
- Reset mid-operation: everything returns to reset values immediately; no partial push.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched[15:0] (incremented per pushed instruction) and perf_killed[15:0] (incremented per killed in-flight response plus entries flushed by redirect).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg: ADDR_W/DATA_W defaults, PC_STEP=4, IDLE/RUN/HOLD state encoding, and the queue entry layout {instr, pc}.
- Sub-module fetch_queue: synchronous FIFO parameterised by width and depth, with push/pop/flush and count output. The top keeps the FSM, PC and in-flight tracking.

Test Plan:
- Reset then out_ready=1 with memory word[a]=0xA000_0000+a -> first out_valid at cycle 3 after reset release; out_pc 0x00, 0x04, 0x08 with matching instructions, one per cycle.
- out_ready=0 for 10 cycles -> exactly 4 requests issued, then imem_rd_en=0; out_instr/out_pc stay at PC 0x00 until ready rises.
- Redirect to 0x42 while queue holds 3 entries and a read is in flight -> queue empty next cycle; no entry from the old stream appears; next out_pc=0x40.
- Start pc at 0xF8 -> output PCs 0xF8, 0xFC, 0x00, 0x04.
- halt=1 for 5 cycles mid-stream -> no imem_rd_en during hold; the in-flight instruction is still delivered; resume at the next sequential PC.
- rst_n pulsed low asynchronously between edges with a full queue -> out_valid=0 and busy=0 immediately; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.
